// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM timebase controller and pwm_gen.
package pwm_pkg;

  localparam int unsigned CNT_W_DEF  = 16;
  localparam int unsigned PSC_W_DEF  = 8;
  localparam int unsigned FUNC_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } pwm_state_e;

  // Alignment field occupies functions[1:0]; decoded by pwm_gen.
  localparam int unsigned FUNC_ALIGN_LSB = 0;
  localparam int unsigned FUNC_ALIGN_W   = 2;

  typedef enum logic [1:0] {
    ALIGN_LEFT      = 2'd0,
    ALIGN_RIGHT     = 2'd1,
    ALIGN_UNALIGNED = 2'd2
  } pwm_align_e;

endpackage

// File: rtl/pwm_prescaler.sv
// Prescaler: psc counts 0..prescale while enabled, tick on the terminal count.
module pwm_prescaler #(
  parameter int unsigned PSC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [PSC_W-1:0] prescale,
  output logic             tick
);

  logic [PSC_W-1:0] psc;

  assign tick = en && (psc >= prescale);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc <= '0;
    end else if (clr) begin
      psc <= '0;
    end else if (en) begin
      psc <= tick ? '0 : psc + PSC_W'(1);
    end
  end

endmodule

// File: rtl/pwm_timebase_ctrl.sv
// PWM timebase: IDLE/RUN/DRAIN sequencing, prescaled counter, double-buffered config.
// Optional one-shot mode enabled by defining PWM_ONESHOT_EN (adds cfg_oneshot input).
module pwm_timebase_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned PSC_W  = PSC_W_DEF,
  parameter int unsigned FUNC_W = FUNC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_en,
  input  logic              cfg_stop_grace,
  input  logic              cfg_update,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [PSC_W-1:0]  cfg_prescale,
  input  logic [CNT_W-1:0]  cfg_compare1,
  input  logic [CNT_W-1:0]  cfg_compare2,
  input  logic [FUNC_W-1:0] cfg_functions,
`ifdef PWM_ONESHOT_EN
  input  logic              cfg_oneshot,
`endif
  output logic              pwm_en,
  output logic [CNT_W-1:0]  count_val,
  output logic [CNT_W-1:0]  period,
  output logic [CNT_W-1:0]  compare1,
  output logic [CNT_W-1:0]  compare2,
  output logic [FUNC_W-1:0] functions,
  output logic              ovf_pulse,
  output logic              upd_done,
  output logic              busy
);

  pwm_state_e       state_q, state_d;
  logic [PSC_W-1:0] prescale_q;
  logic             pend_q, pend_d;
  logic             load, load_q;
  logic             run_cnt, cnt_clr, en_d;
  logic             tick, boundary;
  logic             start_ok, os_stop;

  pwm_prescaler #(.PSC_W(PSC_W)) u_psc (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (state_q != IDLE),
    .clr      (cnt_clr),
    .prescale (prescale_q),
    .tick     (tick)
  );

  assign boundary = tick && (count_val >= period);
  assign busy     = (state_q != IDLE);

`ifdef PWM_ONESHOT_EN
  // After a one-shot completes, cfg_en must be seen low before the next start.
  logic os_block_q;
  assign start_ok = cfg_en && !os_block_q;
  assign os_stop  = cfg_oneshot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) os_block_q <= 1'b0;
    else        os_block_q <= cfg_en && (os_block_q || (run_cnt && boundary && state_d == IDLE));
  end
`else
  assign start_ok = cfg_en;
  assign os_stop  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    load    = 1'b0;
    run_cnt = 1'b0;
    cnt_clr = 1'b0;
    en_d    = pwm_en;
    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = RUN;
          load    = 1'b1;
          cnt_clr = 1'b1;
          en_d    = 1'b1;
          pend_d  = 1'b0;
        end else if (cfg_update) begin
          load = 1'b1;
        end
      end
      RUN: begin
        if (!cfg_en && !cfg_stop_grace) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
          en_d    = 1'b0;
          pend_d  = 1'b0;
        end else begin
          run_cnt = 1'b1;
          if (boundary && (!cfg_en || os_stop)) begin
            state_d = IDLE;
            en_d    = 1'b0;
          end else if (!cfg_en) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        run_cnt = 1'b1;
        if (boundary && (!cfg_en || os_stop)) begin
          state_d = IDLE;
          en_d    = 1'b0;
        end else if (cfg_en) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_clr = 1'b1;
        en_d    = 1'b0;
      end
    endcase
    // A request coinciding with the boundary is applied at that boundary.
    if (run_cnt) begin
      if (boundary) begin
        load   = pend_q || cfg_update;
        pend_d = 1'b0;
      end else if (cfg_update) begin
        pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pend_q     <= 1'b0;
      pwm_en     <= 1'b0;
      count_val  <= '0;
      ovf_pulse  <= 1'b0;
      load_q     <= 1'b0;
      upd_done   <= 1'b0;
      period     <= '0;
      prescale_q <= '0;
      compare1   <= '0;
      compare2   <= '0;
      functions  <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      pwm_en    <= en_d;
      ovf_pulse <= run_cnt && boundary;
      load_q    <= load;
      upd_done  <= load_q;
      if (cnt_clr) begin
        count_val <= '0;
      end else if (run_cnt && tick) begin
        count_val <= boundary ? '0 : count_val + CNT_W'(1);
      end
      if (load) begin
        period     <= cfg_period;
        prescale_q <= cfg_prescale;
        compare1   <= cfg_compare1;
        compare2   <= cfg_compare2;
        functions  <= cfg_functions;
      end
    end
  end

endmodule

// File: tb/tb_pwm_timebase_ctrl.sv
// Directed self-checking bench for pwm_timebase_ctrl (one-shot tests when PWM_ONESHOT_EN is defined).
module tb_pwm_timebase_ctrl;

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned PSC_W  = 8;
  localparam int unsigned FUNC_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_en, cfg_stop_grace, cfg_update;
  logic [CNT_W-1:0]  cfg_period, cfg_compare1, cfg_compare2;
  logic [PSC_W-1:0]  cfg_prescale;
  logic [FUNC_W-1:0] cfg_functions;
`ifdef PWM_ONESHOT_EN
  logic              cfg_oneshot;
`endif
  logic              pwm_en, ovf_pulse, upd_done, busy;
  logic [CNT_W-1:0]  count_val, period, compare1, compare2;
  logic [FUNC_W-1:0] functions;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pwm_timebase_ctrl #(.CNT_W(CNT_W), .PSC_W(PSC_W), .FUNC_W(FUNC_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_en         (cfg_en),
    .cfg_stop_grace (cfg_stop_grace),
    .cfg_update     (cfg_update),
    .cfg_period     (cfg_period),
    .cfg_prescale   (cfg_prescale),
    .cfg_compare1   (cfg_compare1),
    .cfg_compare2   (cfg_compare2),
    .cfg_functions  (cfg_functions),
`ifdef PWM_ONESHOT_EN
    .cfg_oneshot    (cfg_oneshot),
`endif
    .pwm_en         (pwm_en),
    .count_val      (count_val),
    .period         (period),
    .compare1       (compare1),
    .compare2       (compare2),
    .functions      (functions),
    .ovf_pulse      (ovf_pulse),
    .upd_done       (upd_done),
    .busy           (busy)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic stop_idle();
    cfg_en = 1'b0;
    cfg_stop_grace = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cfg_en = 1'b0; cfg_stop_grace = 1'b0; cfg_update = 1'b0;
    cfg_period = '0; cfg_prescale = '0; cfg_compare1 = '0; cfg_compare2 = '0;
    cfg_functions = '0;
`ifdef PWM_ONESHOT_EN
    cfg_oneshot = 1'b0;
`endif
    step(); step();
    n_vec++; if (count_val !== 16'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", count_val); end
    n_vec++; if (pwm_en !== 1'b0) begin n_err++; $display("FAIL reset_pwm_en: got %b expected 0", pwm_en); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_vec++; if (ovf_pulse !== 1'b0 || upd_done !== 1'b0) begin n_err++; $display("FAIL reset_pulses: got ovf=%b upd=%b expected 0 0", ovf_pulse, upd_done); end
    n_vec++; if (period !== 16'd0 || compare1 !== 16'd0 || compare2 !== 16'd0 || functions !== 8'd0) begin
      n_err++; $display("FAIL reset_active: got %0d %0d %0d %0d expected all 0", period, compare1, compare2, functions); end
    rst_n = 1'b1;
    step();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_hold: got busy=%b expected 0", busy); end
  endtask

  task automatic test_start();
    int exp_cnt [9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
    bit exp_ovf [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
    cfg_period = 16'd3; cfg_prescale = 8'd0; cfg_compare1 = 16'd1; cfg_compare2 = 16'd2;
    cfg_functions = 8'h5A; cfg_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      n_vec++; if (count_val !== CNT_W'(exp_cnt[i])) begin n_err++; $display("FAIL start_count[%0d]: got %0d expected %0d", i, count_val, exp_cnt[i]); end
      n_vec++; if (ovf_pulse !== exp_ovf[i]) begin n_err++; $display("FAIL start_ovf[%0d]: got %b expected %b", i, ovf_pulse, exp_ovf[i]); end
      n_vec++; if (upd_done !== (i == 1)) begin n_err++; $display("FAIL start_upd_done[%0d]: got %b expected %b", i, upd_done, (i == 1)); end
      if (i == 0) begin
        n_vec++; if (pwm_en !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL start_en: got pwm_en=%b busy=%b expected 1 1", pwm_en, busy); end
        n_vec++; if (period !== 16'd3 || compare1 !== 16'd1 || compare2 !== 16'd2 || functions !== 8'h5A) begin
          n_err++; $display("FAIL start_load: got %0d %0d %0d %h expected 3 1 2 5a", period, compare1, compare2, functions); end
      end
    end
  endtask

  task automatic test_prescale();
    int exp_cnt [13] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1, 0};
    stop_idle();
    cfg_period = 16'd1; cfg_prescale = 8'd2; cfg_en = 1'b1;
    for (int i = 0; i < 13; i++) begin
      step();
      n_vec++; if (count_val !== CNT_W'(exp_cnt[i])) begin n_err++; $display("FAIL psc_count[%0d]: got %0d expected %0d", i, count_val, exp_cnt[i]); end
      n_vec++; if (ovf_pulse !== (i == 6 || i == 12)) begin n_err++; $display("FAIL psc_ovf[%0d]: got %b expected %b", i, ovf_pulse, (i == 6 || i == 12)); end
    end
  endtask

  task automatic test_shadow();
    stop_idle();
    cfg_period = 16'd3; cfg_prescale = 8'd0; cfg_compare1 = 16'd1; cfg_en = 1'b1;
    step(); step();
    n_vec++; if (count_val !== 16'd1) begin n_err++; $display("FAIL shd_pre_count: got %0d expected 1", count_val); end
    cfg_update = 1'b1; cfg_compare1 = 16'd2;
    step();
    cfg_update = 1'b0;
    n_vec++; if (count_val !== 16'd2 || compare1 !== 16'd1) begin n_err++; $display("FAIL shd_hold_a: got cnt=%0d cmp1=%0d expected 2 1", count_val, compare1); end
    step();
    n_vec++; if (count_val !== 16'd3 || compare1 !== 16'd1 || upd_done !== 1'b0) begin n_err++; $display("FAIL shd_hold_b: got cnt=%0d cmp1=%0d upd=%b expected 3 1 0", count_val, compare1, upd_done); end
    step();
    n_vec++; if (count_val !== 16'd0 || compare1 !== 16'd2 || upd_done !== 1'b0) begin n_err++; $display("FAIL shd_apply: got cnt=%0d cmp1=%0d upd=%b expected 0 2 0", count_val, compare1, upd_done); end
    step();
    n_vec++; if (upd_done !== 1'b1 || count_val !== 16'd1) begin n_err++; $display("FAIL shd_upd_done: got upd=%b cnt=%0d expected 1 1", upd_done, count_val); end
    step();
    n_vec++; if (upd_done !== 1'b0) begin n_err++; $display("FAIL shd_upd_pulse: got %b expected 0", upd_done); end
  endtask

  task automatic test_stop_immediate();
    bit found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (count_val == 16'd1) found = 1'b1;
      else step();
    end
    n_vec++; if (!found) begin n_err++; $display("FAIL imm_wait: got no count=1 within 8 clk expected count=1"); end
    cfg_en = 1'b0; cfg_stop_grace = 1'b0;
    step();
    n_vec++; if (pwm_en !== 1'b0 || count_val !== 16'd0 || busy !== 1'b0) begin
      n_err++; $display("FAIL imm_stop: got pwm_en=%b cnt=%0d busy=%b expected 0 0 0", pwm_en, count_val, busy); end
    n_vec++; if (compare1 !== 16'd2) begin n_err++; $display("FAIL imm_hold_regs: got cmp1=%0d expected 2", compare1); end
  endtask

  task automatic test_stop_grace();
    cfg_compare2 = 16'd2; cfg_en = 1'b1;
    step(); step();
    n_vec++; if (count_val !== 16'd1) begin n_err++; $display("FAIL grc_pre_count: got %0d expected 1", count_val); end
    cfg_en = 1'b0; cfg_stop_grace = 1'b1;
    step();
    n_vec++; if (count_val !== 16'd2 || busy !== 1'b1 || pwm_en !== 1'b1) begin
      n_err++; $display("FAIL grc_drain_a: got cnt=%0d busy=%b en=%b expected 2 1 1", count_val, busy, pwm_en); end
    cfg_update = 1'b1; cfg_compare2 = 16'd7;
    step();
    cfg_update = 1'b0;
    n_vec++; if (count_val !== 16'd3 || compare2 !== 16'd2) begin n_err++; $display("FAIL grc_drain_b: got cnt=%0d cmp2=%0d expected 3 2", count_val, compare2); end
    step();
    n_vec++; if (count_val !== 16'd0 || busy !== 1'b0 || pwm_en !== 1'b0 || ovf_pulse !== 1'b1) begin
      n_err++; $display("FAIL grc_end: got cnt=%0d busy=%b en=%b ovf=%b expected 0 0 0 1", count_val, busy, pwm_en, ovf_pulse); end
    n_vec++; if (compare2 !== 16'd7) begin n_err++; $display("FAIL grc_pend_apply: got cmp2=%0d expected 7", compare2); end
    step();
    n_vec++; if (upd_done !== 1'b1 || busy !== 1'b0 || count_val !== 16'd0) begin
      n_err++; $display("FAIL grc_upd_done: got upd=%b busy=%b cnt=%0d expected 1 0 0", upd_done, busy, count_val); end
    cfg_stop_grace = 1'b0;
  endtask

  task automatic test_idle_update();
    cfg_period = 16'd5; cfg_update = 1'b1;
    step();
    cfg_update = 1'b0;
    n_vec++; if (period !== 16'd5 || upd_done !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL idl_load: got per=%0d upd=%b busy=%b expected 5 0 0", period, upd_done, busy); end
    step();
    n_vec++; if (upd_done !== 1'b1 || count_val !== 16'd0) begin n_err++; $display("FAIL idl_upd_done: got upd=%b cnt=%0d expected 1 0", upd_done, count_val); end
  endtask

  task automatic test_period0();
    bit exp_ovf [5] = '{0, 0, 1, 0, 1};
    cfg_period = 16'd0; cfg_prescale = 8'd1; cfg_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_vec++; if (count_val !== 16'd0) begin n_err++; $display("FAIL p0_count[%0d]: got %0d expected 0", i, count_val); end
      n_vec++; if (ovf_pulse !== exp_ovf[i]) begin n_err++; $display("FAIL p0_ovf[%0d]: got %b expected %b", i, ovf_pulse, exp_ovf[i]); end
    end
    stop_idle();
  endtask

  task automatic test_drain_reenter();
    cfg_period = 16'd3; cfg_prescale = 8'd0; cfg_en = 1'b1;
    step(); step();
    cfg_en = 1'b0; cfg_stop_grace = 1'b1;
    step();
    n_vec++; if (count_val !== 16'd2 || busy !== 1'b1) begin n_err++; $display("FAIL dre_drain: got cnt=%0d busy=%b expected 2 1", count_val, busy); end
    cfg_en = 1'b1;
    step();
    n_vec++; if (count_val !== 16'd3) begin n_err++; $display("FAIL dre_cont: got cnt=%0d expected 3", count_val); end
    step();
    n_vec++; if (count_val !== 16'd0 || ovf_pulse !== 1'b1 || busy !== 1'b1 || pwm_en !== 1'b1) begin
      n_err++; $display("FAIL dre_wrap: got cnt=%0d ovf=%b busy=%b en=%b expected 0 1 1 1", count_val, ovf_pulse, busy, pwm_en); end
    step();
    n_vec++; if (count_val !== 16'd1 || busy !== 1'b1) begin n_err++; $display("FAIL dre_run: got cnt=%0d busy=%b expected 1 1", count_val, busy); end
    stop_idle();
  endtask

  task automatic test_async_reset();
    cfg_en = 1'b1;
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (count_val !== 16'd0 || busy !== 1'b0 || pwm_en !== 1'b0 || period !== 16'd0) begin
      n_err++; $display("FAIL arst: got cnt=%0d busy=%b en=%b per=%0d expected 0 0 0 0", count_val, busy, pwm_en, period); end
    cfg_en = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    n_vec++; if (busy !== 1'b0 || count_val !== 16'd0) begin n_err++; $display("FAIL arst_release: got busy=%b cnt=%0d expected 0 0", busy, count_val); end
  endtask

`ifdef PWM_ONESHOT_EN
  task automatic test_oneshot();
    int exp_cnt [4] = '{0, 1, 2, 0};
    bit exp_busy [4] = '{1, 1, 1, 0};
    cfg_period = 16'd2; cfg_prescale = 8'd0; cfg_oneshot = 1'b1; cfg_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_vec++; if (count_val !== CNT_W'(exp_cnt[i]) || busy !== exp_busy[i]) begin
        n_err++; $display("FAIL os_seq[%0d]: got cnt=%0d busy=%b expected %0d %b", i, count_val, busy, exp_cnt[i], exp_busy[i]); end
    end
    step();
    n_vec++; if (busy !== 1'b0 || pwm_en !== 1'b0) begin n_err++; $display("FAIL os_no_restart: got busy=%b en=%b expected 0 0", busy, pwm_en); end
    cfg_en = 1'b0;
    step();
    cfg_en = 1'b1;
    step();
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL os_restart: got busy=%b expected 1", busy); end
    cfg_oneshot = 1'b0;
    stop_idle();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_start();
    test_prescale();
    test_shadow();
    test_stop_immediate();
    test_stop_grace();
    test_idle_update();
    test_period0();
    test_drain_reenter();
    test_async_reset();
`ifdef PWM_ONESHOT_EN
    test_oneshot();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
